// File: rtl/data_mem_arbiter.sv
// Shares the single Memory data port between the CPU and a DMA master.
// The CPU has priority; a starvation counter forces DMA slots and a bounded lock supports read-modify-write.
module data_mem_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_lock,
    input  logic [14:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_gnt,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_in,
    output logic        mem_load,
    input  logic [15:0] mem_out,
    output logic [15:0] stall_count
);

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);
    localparam logic       LOCK_EN    = (LOCK_MAX > 1);

    state_t      st_q, st_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Reset is active-low here: while it is low nobody owns the port.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (reset) begin
            if (st_q == LOCKED && dma_req) begin
                dma_gnt = 1'b1;
            end else if (dma_req && starve_cnt_q >= STARVE_LIM) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_in    = cpu_wdata;
        mem_load  = cpu_gnt & cpu_we;
        if (dma_gnt) begin
            mem_addr = dma_addr;
            mem_in   = dma_wdata;
            mem_load = dma_we;
        end
        cpu_stall = reset & cpu_req & ~cpu_gnt;
    end

    assign cpu_rdata   = mem_out;
    assign dma_rdata   = mem_out;
    assign stall_count = stall_count_q;

    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        st_d          = st_q;
        lock_cnt_d    = lock_cnt_q;
        stall_count_d = stall_count_q;

        if (dma_gnt) begin
            starve_cnt_d = 8'd0;
        end else if (dma_req) begin
            starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 8'd1;
        end else begin
            starve_cnt_d = 8'd0;
        end

        // Lock length counts granted cycles; the last allowed one returns to OPEN.
        case (st_q)
            OPEN: begin
                if (dma_gnt && dma_lock && LOCK_EN) begin
                    st_d       = LOCKED;
                    lock_cnt_d = 8'd1;
                end
            end
            LOCKED: begin
                if (dma_gnt && dma_lock && lock_cnt_q < LOCK_LAST) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end else begin
                    st_d       = OPEN;
                    lock_cnt_d = 8'd0;
                end
            end
            default: begin
                st_d       = OPEN;
                lock_cnt_d = 8'd0;
            end
        endcase

        if (cpu_stall && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            st_q          <= OPEN;
            starve_cnt_q  <= 8'd0;
            lock_cnt_q    <= 8'd0;
            stall_count_q <= 16'd0;
        end else begin
            st_q          <= st_d;
            starve_cnt_q  <= starve_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed cycles push expectations, negedge monitors compare.
// A second instance with a long lock limit drives the stall counter into saturation.
module tb_data_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [14:0] cpu_addr, dma_addr;
    logic [15:0] cpu_wdata, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_in, mem_out, stall_count;
    logic        cpu_gnt, cpu_stall, dma_gnt, mem_load;
    logic [14:0] mem_addr;

    logic        s_reset, s_cpu_req, s_dma_req, s_dma_lock;
    logic        s_zero_bit;
    logic [14:0] s_zero_addr;
    logic [15:0] s_zero_data;
    logic [15:0] s_cpu_rdata, s_dma_rdata, s_mem_in, s_stall_count;
    logic        s_cpu_gnt, s_cpu_stall, s_dma_gnt, s_mem_load;
    logic [14:0] s_mem_addr;

    data_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_gnt(dma_gnt),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out),
        .stall_count(stall_count)
    );

    data_mem_arbiter #(.STARVE_MAX(8), .LOCK_MAX(255)) dut_sat (
        .clock(clock), .reset(s_reset),
        .cpu_req(s_cpu_req), .cpu_we(s_zero_bit), .cpu_addr(s_zero_addr), .cpu_wdata(s_zero_data),
        .cpu_rdata(s_cpu_rdata), .cpu_gnt(s_cpu_gnt), .cpu_stall(s_cpu_stall),
        .dma_req(s_dma_req), .dma_we(s_zero_bit), .dma_lock(s_dma_lock), .dma_addr(s_zero_addr),
        .dma_wdata(s_zero_data), .dma_rdata(s_dma_rdata), .dma_gnt(s_dma_gnt),
        .mem_addr(s_mem_addr), .mem_in(s_mem_in), .mem_load(s_mem_load), .mem_out(s_zero_data),
        .stall_count(s_stall_count)
    );

    // Memory model: combinational read, store on the falling edge.
    logic [15:0] mem [0:32767];
    initial for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    always @(negedge clock) if (mem_load) mem[mem_addr] <= mem_in;
    assign mem_out = mem[mem_addr];

    typedef struct {
        logic        rst, cr, cw;
        logic [14:0] ca;
        logic [15:0] cd;
        logic        dr, dw, dl;
        logic [14:0] da;
        logic [15:0] dd;
    } stim_t;

    typedef struct {
        string       name;
        logic        cg, dg, ld, stl;
        logic        chk_rd;
        logic [15:0] rd;
        logic        chk_sc;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t sat_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic stim_t mk_stim(input logic rst, input logic cr, input logic cw,
                                      input logic [14:0] ca, input logic [15:0] cd,
                                      input logic dr, input logic dw, input logic dl,
                                      input logic [14:0] da, input logic [15:0] dd);
        stim_t s;
        s.rst = rst; s.cr = cr; s.cw = cw; s.ca = ca; s.cd = cd;
        s.dr = dr; s.dw = dw; s.dl = dl; s.da = da; s.dd = dd;
        return s;
    endfunction

    function automatic exp_t mk_exp(input string name, input logic cg, input logic dg,
                                    input logic ld, input logic stl,
                                    input logic chk_rd, input logic [15:0] rd,
                                    input logic chk_sc, input logic [15:0] sc);
        exp_t e;
        e.name = name; e.cg = cg; e.dg = dg; e.ld = ld; e.stl = stl;
        e.chk_rd = chk_rd; e.rd = rd; e.chk_sc = chk_sc; e.sc = sc;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input stim_t s, input exp_t e);
        @(posedge clock);
        #1;
        reset = s.rst; cpu_req = s.cr; cpu_we = s.cw; cpu_addr = s.ca; cpu_wdata = s.cd;
        dma_req = s.dr; dma_we = s.dw; dma_lock = s.dl; dma_addr = s.da; dma_wdata = s.dd;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({e.name, ".cpu_gnt"}, 16'(cpu_gnt), 16'(e.cg));
            checkOutput({e.name, ".dma_gnt"}, 16'(dma_gnt), 16'(e.dg));
            checkOutput({e.name, ".mem_load"}, 16'(mem_load), 16'(e.ld));
            checkOutput({e.name, ".cpu_stall"}, 16'(cpu_stall), 16'(e.stl));
            if (e.chk_rd) begin
                checkOutput({e.name, ".cpu_rdata"}, cpu_rdata, e.rd);
                checkOutput({e.name, ".dma_rdata"}, dma_rdata, e.rd);
            end
            if (e.chk_sc) checkOutput({e.name, ".stall_count"}, stall_count, e.sc);
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (sat_q.size() > 0) begin
            e = sat_q.pop_front();
            checkOutput({e.name, ".cpu_gnt"}, 16'(s_cpu_gnt), 16'(e.cg));
            checkOutput({e.name, ".dma_gnt"}, 16'(s_dma_gnt), 16'(e.dg));
            checkOutput({e.name, ".cpu_stall"}, 16'(s_cpu_stall), 16'(e.stl));
            checkOutput({e.name, ".stall_count"}, s_stall_count, e.sc);
        end
    end

    initial begin
        #1_500_000;
        failures++;
        $display("[TB] FAIL watchdog simulation time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int          sc_model;
        logic        dg_k, stall_k;
        logic [15:0] rd_k;

        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'h0; cpu_wdata = 16'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 15'h0; dma_wdata = 16'h0;
        s_reset = 1'b0; s_cpu_req = 1'b0; s_dma_req = 1'b0; s_dma_lock = 1'b0;
        s_zero_bit = 1'b0; s_zero_addr = 15'h0; s_zero_data = 16'h0;

        // Reset held low with everything requesting, then release.
        for (int i = 0; i < 3; i++)
            applyStimulus(mk_stim(1'b0, 1'b1, 1'b1, 15'h0100, 16'h5555, 1'b1, 1'b1, 1'b0, 15'h0200, 16'h6666),
                          mk_exp($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, (i > 0), 16'h0));
        applyStimulus(mk_stim(1'b1, 1'b1, 1'b1, 15'h0100, 16'h5555, 1'b1, 1'b1, 1'b0, 15'h0200, 16'h6666),
                      mk_exp("release", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0));
        applyStimulus(mk_stim(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0),
                      mk_exp("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0));

        // CPU store then load.
        applyStimulus(mk_stim(1'b1, 1'b1, 1'b1, 15'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0),
                      mk_exp("cpu_store", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0));
        applyStimulus(mk_stim(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0),
                      mk_exp("cpu_load", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h0));

        // Continuous contention: DMA forced every ninth cycle, its store only then.
        for (int k = 1; k <= 27; k++) begin
            dg_k = ((k % 9) == 0);
            applyStimulus(mk_stim(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 1'b1, 1'b0, 15'h0300, 16'h0A0A),
                          mk_exp($sformatf("contend%0d", k), !dg_k, dg_k, dg_k, dg_k,
                                 !dg_k, 16'h1234, 1'b1, 16'((k - 1) / 9)));
        end
        applyStimulus(mk_stim(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0),
                      mk_exp("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd3));

        // Forced grant with lock held: four DMA cycles, write then read back the screen word.
        for (int k = 1; k <= 13; k++) begin
            dg_k = (k >= 9 && k <= 12);
            rd_k = (k >= 10 && k <= 12) ? 16'hBEEF : 16'h1234;
            applyStimulus(mk_stim(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, (k == 9), 1'b1, 15'h4000, 16'hBEEF),
                          mk_exp($sformatf("lock%0d", k), !dg_k, dg_k, (k == 9), dg_k,
                                 (k != 9), rd_k, 1'b1,
                                 16'(3 + ((k <= 9) ? 0 : ((k >= 13) ? 4 : k - 9)))));
        end
        applyStimulus(mk_stim(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0),
                      mk_exp("idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd7));

        // Reset pulse on the second locked cycle, then arbitration restarts from OPEN.
        for (int k = 1; k <= 10; k++) begin
            dg_k = (k == 9);
            applyStimulus(mk_stim((k != 10), 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 1'b0, 1'b1, 15'h4000, 16'h0),
                          mk_exp($sformatf("midlock%0d", k), (k <= 8), dg_k, 1'b0, dg_k,
                                 1'b1, dg_k ? 16'hBEEF : 16'h1234, 1'b1, (k == 10) ? 16'd8 : 16'd7));
        end
        for (int r = 1; r <= 9; r++) begin
            dg_k = (r == 9);
            applyStimulus(mk_stim(1'b1, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b1, 1'b0, 1'b1, 15'h4000, 16'h0),
                          mk_exp($sformatf("after_rst%0d", r), !dg_k, dg_k, 1'b0, dg_k,
                                 1'b1, dg_k ? 16'hBEEF : 16'h1234, 1'b1, 16'h0));
        end
        applyStimulus(mk_stim(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0),
                      mk_exp("idle3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd1));
        applyStimulus(mk_stim(1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0),
                      mk_exp("idle4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd1));

        // Saturation: an unstalled open DMA grant starts a 255-cycle lock, the CPU stalls 254 of them.
        sc_model = 0;
        for (int j = 0; j < 259 * 255; j++) begin
            stall_k = ((j % 255) != 0);
            @(posedge clock);
            #1;
            s_reset = 1'b1; s_cpu_req = stall_k; s_dma_req = 1'b1; s_dma_lock = 1'b1;
            if (sc_model == 1000 || sc_model >= 65533)
                sat_q.push_back(mk_exp($sformatf("sat%0d", j), 1'b0, 1'b1, 1'b0, stall_k,
                                       1'b0, 16'h0, 1'b1, 16'(sc_model)));
            if (stall_k && sc_model < 65535) sc_model++;
        end
        @(posedge clock);
        #1;
        s_cpu_req = 1'b0; s_dma_req = 1'b0; s_dma_lock = 1'b0;
        @(posedge clock);
        @(posedge clock);
        checkOutput("scoreboard_drain", 16'(exp_q.size() + sat_q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
